// File: rtl/lsu_pkg.sv
// lsu_pkg: shared encodings for the load/store unit.
//   - request size encodings
//   - FSM state enum
//   - byte-enable constants
package lsu_pkg;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  localparam logic [3:0] BE_NONE    = 4'b0000;
  localparam logic [3:0] BE_BYTE0   = 4'b0001;
  localparam logic [3:0] BE_HALF_LO = 4'b0011;
  localparam logic [3:0] BE_HALF_HI = 4'b1100;
  localparam logic [3:0] BE_WORD    = 4'b1111;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'b00,
    ST_ACCESS = 2'b01,
    ST_RESP   = 2'b10
  } lsu_state_e;

endpackage

// File: rtl/lsu_align.sv
// lsu_align: combinational alignment helpers for the load/store unit.
// Request side:
//   req_off, req_size, req_wdata -> misalign flag, byte enables, lane-replicated store data
// Load side:
//   ld_off, ld_size, ld_unsigned, ld_raw -> lane-extracted, sign/zero-extended load data
module lsu_align
  import lsu_pkg::*;
(
  input  logic [1:0]  req_off,
  input  logic [1:0]  req_size,
  input  logic [31:0] req_wdata,
  output logic        misalign,
  output logic [3:0]  be,
  output logic [31:0] wdata_rep,
  input  logic [1:0]  ld_off,
  input  logic [1:0]  ld_size,
  input  logic        ld_unsigned,
  input  logic [31:0] ld_raw,
  output logic [31:0] ld_data
);

  logic [7:0]  ld_byte;
  logic [15:0] ld_half;

  always_comb begin
    misalign  = 1'b0;
    be        = BE_NONE;
    wdata_rep = req_wdata;
    case (req_size)
      SZ_BYTE: begin
        be        = BE_BYTE0 << req_off;
        wdata_rep = {4{req_wdata[7:0]}};
      end
      SZ_HALF: begin
        misalign  = req_off[0];
        be        = req_off[1] ? BE_HALF_HI : BE_HALF_LO;
        wdata_rep = {2{req_wdata[15:0]}};
      end
      SZ_WORD: begin
        misalign  = (req_off != 2'b00);
        be        = BE_WORD;
      end
      default: misalign = 1'b1;
    endcase
  end

  always_comb begin
    ld_byte = ld_raw[7:0];
    case (ld_off)
      2'd0:    ld_byte = ld_raw[7:0];
      2'd1:    ld_byte = ld_raw[15:8];
      2'd2:    ld_byte = ld_raw[23:16];
      default: ld_byte = ld_raw[31:24];
    endcase
    ld_half = ld_off[1] ? ld_raw[31:16] : ld_raw[15:0];
    case (ld_size)
      SZ_BYTE: ld_data = {{24{~ld_unsigned & ld_byte[7]}}, ld_byte};
      SZ_HALF: ld_data = {{16{~ld_unsigned & ld_half[15]}}, ld_half};
      default: ld_data = ld_raw;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// load_store_unit: memory-access stage behind the ALU.
// Core side:   req_valid/req_we/req_size/req_unsigned/req_addr/req_wdata in;
//              stall (combinational), done, rdata, err_misalign, err_bus out.
// Memory side: mem_req/mem_we/mem_addr/mem_be/mem_wdata out (stable while mem_req);
//              mem_rdata/mem_ready in.
// Clock clk, synchronous active-low reset rst_n.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  input  logic        req_we,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        stall,
  output logic        done,
  output logic [31:0] rdata,
  output logic        err_misalign,
  output logic        err_bus,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [3:0]  mem_be,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ready
);

  localparam int CNT_W = $clog2(TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  lsu_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q;
  logic             op_we;
  logic [1:0]       op_size;
  logic             op_unsigned;
  logic [1:0]       op_off;

  logic        accept, misalign_hit, ready_hit, timeout_hit;
  logic        req_misalign;
  logic [3:0]  req_be;
  logic [31:0] req_wdata_rep;
  logic [31:0] ld_data;

  lsu_align u_align (
    .req_off     (req_addr[1:0]),
    .req_size    (req_size),
    .req_wdata   (req_wdata),
    .misalign    (req_misalign),
    .be          (req_be),
    .wdata_rep   (req_wdata_rep),
    .ld_off      (op_off),
    .ld_size     (op_size),
    .ld_unsigned (op_unsigned),
    .ld_raw      (mem_rdata),
    .ld_data     (ld_data)
  );

  assign stall = req_valid & (state_q != ST_RESP);

  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d      = state_q;
    accept       = 1'b0;
    misalign_hit = 1'b0;
    ready_hit    = 1'b0;
    timeout_hit  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          if (req_misalign) begin
            misalign_hit = 1'b1;
            state_d      = ST_RESP;
          end else begin
            accept  = 1'b1;
            state_d = ST_ACCESS;
          end
        end
      end
      ST_ACCESS: begin
        // ready in the last permitted cycle still completes normally
        if (mem_ready) begin
          ready_hit = 1'b1;
          state_d   = ST_RESP;
        end else if (cnt_q == CNT_LAST) begin
          timeout_hit = 1'b1;
          state_d     = ST_RESP;
        end
      end
      ST_RESP: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // done/err are set on the edge entering RESP so they are high exactly in RESP
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q        <= '0;
      op_we        <= 1'b0;
      op_size      <= SZ_BYTE;
      op_unsigned  <= 1'b0;
      op_off       <= 2'b00;
      done         <= 1'b0;
      err_misalign <= 1'b0;
      err_bus      <= 1'b0;
      rdata        <= '0;
      mem_req      <= 1'b0;
      mem_we       <= 1'b0;
      mem_addr     <= '0;
      mem_be       <= BE_NONE;
      mem_wdata    <= '0;
    end else begin
      done         <= misalign_hit | ready_hit | timeout_hit;
      err_misalign <= misalign_hit;
      err_bus      <= timeout_hit;
      if (accept) begin
        cnt_q       <= '0;
        op_we       <= req_we;
        op_size     <= req_size;
        op_unsigned <= req_unsigned;
        op_off      <= req_addr[1:0];
        mem_req     <= 1'b1;
        mem_we      <= req_we;
        mem_addr    <= {req_addr[31:2], 2'b00};
        mem_be      <= req_be;
        mem_wdata   <= req_wdata_rep;
      end
      if (state_q == ST_ACCESS && !mem_ready)
        cnt_q <= cnt_q + 1'b1;
      if (ready_hit || timeout_hit)
        mem_req <= 1'b0;
      if (ready_hit && !op_we)
        rdata <= ld_data;
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
module tb_load_store_unit;

  localparam int TO = 16;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid, req_we, req_unsigned;
  logic [1:0]  req_size;
  logic [31:0] req_addr, req_wdata;
  logic        stall, done, err_misalign, err_bus;
  logic [31:0] rdata;
  logic        mem_req, mem_we, mem_ready;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [3:0]  mem_be;

  int n_tests = 0;
  int n_fail  = 0;
  logic [31:0] rdata_m = 32'h0;

  load_store_unit #(.TIMEOUT(TO)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_we(req_we), .req_size(req_size),
    .req_unsigned(req_unsigned), .req_addr(req_addr), .req_wdata(req_wdata),
    .stall(stall), .done(done), .rdata(rdata),
    .err_misalign(err_misalign), .err_bus(err_bus),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_be(mem_be), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ready(mem_ready)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reference behaviour from the access rules, using plain arithmetic.
  function automatic bit ref_misalign(input logic [1:0] sz, input logic [31:0] a);
    if (sz == 2'b11) return 1'b1;
    if (sz == 2'b01) return (a % 2) != 0;
    if (sz == 2'b10) return (a % 4) != 0;
    return 1'b0;
  endfunction

  function automatic logic [3:0] ref_be(input logic [1:0] sz, input logic [31:0] a);
    if (sz == 2'b00) return 4'(1 << (a % 4));
    if (sz == 2'b01) return 4'(3 << (a & 2));
    return 4'hF;
  endfunction

  function automatic logic [31:0] ref_wdata(input logic [1:0] sz, input logic [31:0] w);
    if (sz == 2'b00) return (w & 32'hFF) * 32'h01010101;
    if (sz == 2'b01) return (w & 32'hFFFF) * 32'h00010001;
    return w;
  endfunction

  function automatic logic [31:0] ref_load(input logic [1:0] sz, input bit uns,
                                           input logic [31:0] a, input logic [31:0] raw);
    logic [31:0] mask, v;
    int sh;
    if (sz == 2'b10) return raw;
    mask = (sz == 2'b00) ? 32'hFF : 32'hFFFF;
    sh   = (sz == 2'b00) ? int'(a % 4) * 8 : int'(a & 2) * 8;
    v    = (raw >> sh) & mask;
    if (!uns && ((v & ((mask >> 1) + 1)) != 0)) v = v | ~mask;
    return v;
  endfunction

  // Starts in the accept cycle (just after an edge); ends in the following idle cycle.
  // rdy_cyc: cycle (after accept) in which mem_ready is driven; > TO means never in time.
  task automatic do_op(input bit we, input logic [1:0] sz, input bit uns,
                       input logic [31:0] a, input logic [31:0] w,
                       input logic [31:0] raw, input int rdy_cyc);
    bit mis;
    int exp_done;
    mis = ref_misalign(sz, a);
    exp_done = mis ? 1 : ((rdy_cyc <= TO) ? rdy_cyc + 1 : TO + 1);
    req_valid = 1'b1; req_we = we; req_size = sz; req_unsigned = uns;
    req_addr = a; req_wdata = w;
    mem_ready = 1'($urandom_range(0, 1));   // ignored while idle
    mem_rdata = $urandom;
    #1;
    chk("stall_accept", {31'b0, stall}, 32'd1);
    for (int c = 1; c <= exp_done; c++) begin
      step();
      chk("done", {31'b0, done}, {31'b0, c == exp_done});
      if (c < exp_done) begin
        chk("mem_req_hi", {31'b0, mem_req}, 32'd1);
        chk("stall_wait", {31'b0, stall}, 32'd1);
        if (c == 1) begin
          chk("mem_addr", mem_addr, a & 32'hFFFF_FFFC);
          chk("mem_be", {28'b0, mem_be}, {28'b0, ref_be(sz, a)});
          chk("mem_we", {31'b0, mem_we}, {31'b0, we});
          if (we) chk("mem_wdata", mem_wdata, ref_wdata(sz, w));
        end
      end else begin
        if (!mis && !we && rdy_cyc <= TO) rdata_m = ref_load(sz, uns, a, raw);
        chk("mem_req_lo", {31'b0, mem_req}, 32'd0);
        chk("stall_resp", {31'b0, stall}, 32'd0);
        chk("err_misalign", {31'b0, err_misalign}, {31'b0, mis});
        chk("err_bus", {31'b0, err_bus}, {31'b0, !mis && rdy_cyc > TO});
        chk("rdata", rdata, rdata_m);
      end
      mem_ready = (!mis && c == rdy_cyc) ? 1'b1 : 1'b0;
      mem_rdata = mem_ready ? raw : $urandom;
    end
    req_valid = 1'b0;
    mem_ready = 1'b0;
    step();
    chk("done_idle", {31'b0, done}, 32'd0);
    chk("mem_req_idle", {31'b0, mem_req}, 32'd0);
  endtask

  initial begin
    logic [1:0]  sz;
    logic [31:0] a;
    int          r;
    rst_n = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_size = 2'b00;
    req_unsigned = 1'b0; req_addr = '0; req_wdata = '0;
    mem_ready = 1'b0; mem_rdata = '0;
    step(); step();
    rst_n = 1'b1;
    chk("rst_rdata", rdata, 32'h0);
    chk("rst_mem_req", {31'b0, mem_req}, 32'd0);
    chk("rst_done", {31'b0, done}, 32'd0);
    chk("rst_mem_be", {28'b0, mem_be}, 32'd0);
    chk("rst_stall", {31'b0, stall}, 32'd0);
    step();

    do_op(1'b1, 2'b10, 1'b0, 32'h100, 32'hDEADBEEF, 32'h0, 1);
    do_op(1'b1, 2'b00, 1'b0, 32'h103, 32'h000000A5, 32'h0, 1);
    do_op(1'b0, 2'b00, 1'b0, 32'h102, 32'h0, 32'h12F45678, 1);
    chk("lb_signed", rdata, 32'hFFFFFFF4);
    do_op(1'b0, 2'b00, 1'b1, 32'h102, 32'h0, 32'h12F45678, 3);
    chk("lbu", rdata, 32'h000000F4);
    do_op(1'b0, 2'b01, 1'b0, 32'h201, 32'h0, 32'h0, 1);
    do_op(1'b0, 2'b10, 1'b0, 32'h300, 32'h0, 32'h55AA55AA, TO + 5);
    do_op(1'b0, 2'b10, 1'b0, 32'h304, 32'h0, 32'h87654321, TO);
    do_op(1'b0, 2'b11, 1'b0, 32'h400, 32'h0, 32'h0, 1);

    // reset while waiting on memory
    req_valid = 1'b1; req_we = 1'b0; req_size = 2'b10; req_addr = 32'h40;
    step(); step(); step();
    rst_n = 1'b0; req_valid = 1'b0;
    step();
    rdata_m = 32'h0;
    chk("midrst_mem_req", {31'b0, mem_req}, 32'd0);
    chk("midrst_done", {31'b0, done}, 32'd0);
    chk("midrst_rdata", rdata, 32'h0);
    chk("midrst_mem_addr", mem_addr, 32'h0);
    chk("midrst_mem_be", {28'b0, mem_be}, 32'd0);
    chk("midrst_mem_we", {31'b0, mem_we}, 32'd0);
    rst_n = 1'b1;
    step();
    do_op(1'b0, 2'b01, 1'b0, 32'h502, 32'h0, 32'h8001_7FFF, 2);
    chk("lh_after_rst", rdata, 32'hFFFF8001);

    for (int i = 0; i < 80; i++) begin
      sz = 2'($urandom_range(0, 3));
      a  = $urandom;
      if ($urandom_range(0, 3) != 0) a = (sz == 2'b01) ? (a & ~32'h1) : (sz == 2'b10 ? a & ~32'h3 : a);
      r  = ($urandom_range(0, 9) == 0) ? $urandom_range(TO - 1, TO + 2) : $urandom_range(1, 4);
      do_op(1'($urandom_range(0, 1)), sz, 1'($urandom_range(0, 1)), a, $urandom, $urandom, r);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/load_store_unit.md
# load_store_unit

Memory-access stage directly downstream of the ALU in the processor datapath. Takes the ALU result as effective address, performs byte/half/word loads and stores against a data memory with a variable-latency ready handshake, and stalls the core until the access completes. Flags misaligned accesses and memory timeouts instead of issuing or hanging.

## Interface

- `TIMEOUT`, 16: maximum ACCESS cycles without `mem_ready` before a bus error; ≥2.
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: reset, synchronous, active-low.
- `req_valid` in 1: core presents a memory op; held stable until the `done` cycle.
- `req_we` in 1: 1 = store, 0 = load.
- `req_size` in 2: 00 byte, 01 half, 10 word, 11 illegal.
- `req_unsigned` in 1: loads zero-extend when 1, sign-extend when 0.
- `req_addr` in 32: effective address (ALU output).
- `req_wdata` in 32: store data; low byte/half used for sub-word stores.
- `stall` out 1: core must hold its PC and pipeline state.
- `done` out 1: one-cycle completion pulse.
- `rdata` out 32: extended load result; valid with `done`, held until the next `done`.
- `err_misalign` out 1: pulses with `done` for a misaligned or illegal-size request.
- `err_bus` out 1: pulses with `done` on timeout.
- `mem_req` out 1: memory request, held until `mem_ready` or timeout.
- `mem_we` out 1, `mem_addr` out 32 (bits [1:0] = 0), `mem_be` out 4, `mem_wdata` out 32: stable while `mem_req` is high.
- `mem_rdata` in 32, `mem_ready` in 1: memory response; `mem_rdata` is sampled in the `mem_ready` cycle.

## Operation

- FSM states are IDLE, ACCESS and RESP.
- **IDLE**
  - With `req_valid` and an aligned request: latch op, address, BE and lane-replicated wdata; go to ACCESS; clear the wait counter.
  - With `req_valid` and a misaligned request: go to RESP with `err_misalign` armed. No `mem_req` is issued.
- **ACCESS**
  - `mem_req` is 1.
  - `mem_ready`: capture the extracted load data into `rdata` (stores leave `rdata` unchanged) and go to RESP.
  - Otherwise the counter increments. When the counter reaches `TIMEOUT`-1 without ready, go to RESP with `err_bus` armed.
  - If ready arrives in the timeout cycle, ready wins.
- **RESP**: `done` is 1, errors pulse if armed, and the next state is IDLE unconditionally.
- `stall` = `req_valid` & (state ≠ RESP).
- `mem_ready` is ignored outside ACCESS.
- Misaligned cases: half with `addr[0]`=1; word with `addr[1:0]`≠0; size 11 always.
- Byte enables:
  - Byte: BE = 1 << `addr[1:0]`, data replicated into all 4 lanes.
  - Half: BE = 0011 when `addr[1]`=0, else 1100; data replicated into both halves.
  - Word: BE = 1111.
- Load extraction: select the lane by `addr[1:0]` (byte) or `addr[1]` (half), then sign- or zero-extend to 32 bits per `req_unsigned`.
- Failed loads (either error) leave `rdata` unchanged.

## Timing

- Reset (`rst_n`=0 at an edge): state goes to IDLE, counter to 0, and `rdata` to 0. `mem_req`, `done`, `err_misalign`, `err_bus`, `mem_we`, `mem_be` and `mem_addr` are 0.
- Reset mid-ACCESS abandons the transaction: `mem_req` is low from the first cycle after that edge.
- Latency, accept cycle = 0:
  - Zero-wait memory (ready in cycle 1): `done` in cycle 2.
  - Each wait cycle adds 1.
  - Misaligned: `done` in cycle 1.
  - Timeout: `done` in cycle `TIMEOUT`+1.
- A back-to-back request may be accepted in the cycle after RESP; there is one idle cycle between ops minimum.
- `stall` is combinational from `req_valid` and state. All other outputs are registered.

## Structure

- Package `lsu_pkg` holds:
  - size encodings (`SZ_BYTE`, `SZ_HALF`, `SZ_WORD`);
  - the FSM state enum;
  - BE constants.
- Sub-module `lsu_align` is combinational: misalign check, BE generation, wdata replication, and load lane extraction/extension.
- The top level holds the FSM, counter and latches.

## Test plan

- Store word 0xDEADBEEF at 0x100, ready in cycle 1 -> `mem_addr`=0x100, BE=1111, `done` in cycle 2, `stall` high in cycles 0–1.
- Store byte 0xA5 at 0x103 -> BE=1000, `mem_wdata`=0xA5A5A5A5.
- Load byte at 0x102 with `mem_rdata`=0x12F45678: signed gives `rdata`=0xFFFFFFF4; unsigned gives 0x000000F4.
- Load half at 0x201 -> `err_misalign`+`done` in cycle 1, no `mem_req`, `rdata` unchanged.
- Load word with `mem_ready` never asserted, `TIMEOUT`=16 -> `mem_req` high for 16 cycles, then `err_bus`+`done`. Also: ready in the final cycle -> no error.
- `rst_n` low during ACCESS wait -> `mem_req`=0 and all outputs at reset values next cycle, then a new request completes normally.
